// File: rtl/burst_cache.sv
// burst_cache: direct-mapped, write-back data cache between a 32-bit CPU
// load/store port and a 64-bit, 4-beat burst RAM. Hits complete in one cycle;
// a miss writes back a dirty victim line, then refills the line.
// Optional build macro: CACHE_STATS_EN adds the stat_hits / stat_misses counters.
module burst_cache #(
  parameter int LineIndexBitWidth  = 1,
  parameter int RamAddressBitWidth = 4,
  parameter int RamAddressingMode  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [3:0]                    write_enable,
  input  logic [31:0]                   address,
  input  logic [31:0]                   data_in,
  output logic [31:0]                   data_out,
  output logic                          data_out_ready,
  output logic                          busy,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RamAddressBitWidth-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                   stat_hits,
  output logic [31:0]                   stat_misses
`endif
);

  localparam int L      = LineIndexBitWidth;
  localparam int Lines  = 1 << L;
  localparam int TagLsb = 5 + L;
  localparam int TagW   = RamAddressBitWidth + RamAddressingMode - TagLsb;

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL_CMD, S_FILL_WAIT, S_DONE
  } state_e;

  state_e state_q, state_d;

  // Line storage and per-line metadata
  logic [63:0]     line_q [Lines][4];
  logic [TagW-1:0] tag_q  [Lines];
  logic [Lines-1:0] valid_q, dirty_q;

  // Latched miss request
  logic [2:0]      req_word_q;
  logic [L-1:0]    req_idx_q;
  logic [TagW-1:0] req_tag_q;
  logic [3:0]      req_we_q;
  logic [31:0]     req_data_q;

  logic [1:0]      beat_q;
  logic [31:0]     data_out_q;
  logic            data_out_ready_q;

  // Decode of the live request
  logic [2:0]      cur_word;
  logic [L-1:0]    cur_idx;
  logic [TagW-1:0] cur_tag;
  logic            lookup_hit;
  logic            unused_addr_bits;

  assign cur_word   = address[4:2];
  assign cur_idx    = address[5 +: L];
  assign cur_tag    = address[TagLsb +: TagW];
  assign lookup_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign unused_addr_bits = ^{address[1:0], address[31:TagLsb+TagW]};

  assign data_out       = data_out_q;
  assign data_out_ready = data_out_ready_q;

  // Byte-lane merge of a 32-bit write into the even (low) or odd (high) half of a beat
  function automatic logic [63:0] merge_word(input logic [63:0] beat, input logic hi,
                                             input logic [3:0] be, input logic [31:0] wdata);
    logic [63:0] r;
    int          off;
    r   = beat;
    off = hi ? 32 : 0;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[off + 8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] select_word(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (which would infer a latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (enable && !lookup_hit)
                     state_d = (valid_q[cur_idx] && dirty_q[cur_idx]) ? S_WB : S_FILL_CMD;
      S_WB:        if (beat_q == 2'd3) state_d = S_FILL_CMD;
      S_FILL_CMD:  state_d = S_FILL_WAIT;
      S_FILL_WAIT: if (br_rd_data_valid && beat_q == 2'd3) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Burst-RAM command outputs and busy flag, decoded from state
  always_comb begin
    busy         = (state_q != S_IDLE);
    br_cmd       = (state_q == S_WB);
    br_cmd_en    = ((state_q == S_WB) && (beat_q == 2'd0)) || (state_q == S_FILL_CMD);
    br_addr      = (state_q == S_WB)
                   ? RamAddressBitWidth'({tag_q[req_idx_q], req_idx_q, 2'b00})
                   : RamAddressBitWidth'({req_tag_q, req_idx_q, 2'b00});
    br_wr_data   = line_q[req_idx_q][beat_q];
    br_data_mask = 8'h00;
  end

  // Control datapath: metadata, request latch, beat counter, read response
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      dirty_q          <= '0;
      beat_q           <= 2'd0;
      data_out_q       <= 32'h0;
      data_out_ready_q <= 1'b0;
      req_word_q       <= 3'd0;
      req_idx_q        <= '0;
      req_tag_q        <= '0;
      req_we_q         <= 4'h0;
      req_data_q       <= 32'h0;
    end else begin
      data_out_ready_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (enable) begin
          if (lookup_hit) begin
            if (write_enable == 4'h0) begin
              data_out_q       <= select_word(line_q[cur_idx][cur_word[2:1]], cur_word[0]);
              data_out_ready_q <= 1'b1;
            end else begin
              dirty_q[cur_idx] <= 1'b1;
            end
          end else begin
            req_word_q <= cur_word;
            req_idx_q  <= cur_idx;
            req_tag_q  <= cur_tag;
            req_we_q   <= write_enable;
            req_data_q <= data_in;
            beat_q     <= 2'd0;
          end
        end
        S_WB:        beat_q <= beat_q + 2'd1;
        S_FILL_WAIT: if (br_rd_data_valid) beat_q <= beat_q + 2'd1;
        S_DONE: begin
          valid_q[req_idx_q] <= 1'b1;
          dirty_q[req_idx_q] <= |req_we_q;
          if (req_we_q == 4'h0) begin
            data_out_q       <= select_word(line_q[req_idx_q][req_word_q[2:1]], req_word_q[0]);
            data_out_ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line data and tag arrays: hit writes, refill beats, miss-write merge
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; the cleared valid bits make their contents irrelevant.
    if (!rst) begin
      unique case (state_q)
        S_IDLE: if (enable && lookup_hit && (write_enable != 4'h0))
          line_q[cur_idx][cur_word[2:1]] <= merge_word(line_q[cur_idx][cur_word[2:1]],
                                                       cur_word[0], write_enable, data_in);
        S_FILL_WAIT: if (br_rd_data_valid) line_q[req_idx_q][beat_q] <= br_rd_data;
        S_DONE: begin
          tag_q[req_idx_q] <= req_tag_q;
          if (req_we_q != 4'h0)
            line_q[req_idx_q][req_word_q[2:1]] <= merge_word(line_q[req_idx_q][req_word_q[2:1]],
                                                             req_word_q[0], req_we_q, req_data_q);
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits_q, stat_misses_q;
  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;

  // Hit / miss counters, one step per accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits_q   <= 32'h0;
      stat_misses_q <= 32'h0;
    end else if (state_q == S_IDLE && enable) begin
      if (lookup_hit) stat_hits_q   <= stat_hits_q + 32'd1;
      else            stat_misses_q <= stat_misses_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_burst_cache.sv
// tb_burst_cache: directed bench for burst_cache with a behavioural burst-RAM model.
`timescale 1ns/1ps
module tb_burst_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  write_enable = 4'h0;
  logic [31:0] address = 32'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [3:0]  br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data = 64'h0;
  logic        br_rd_data_valid = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  int vectors = 0;
  int miscompares = 0;

  burst_cache dut (
    .clk(clk), .rst(rst), .enable(enable), .write_enable(write_enable),
    .address(address), .data_in(data_in), .data_out(data_out),
    .data_out_ready(data_out_ready), .busy(busy), .br_cmd(br_cmd),
    .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  // Burst RAM model: 16 x 64-bit words, read data 2 cycles after the command, one bubble mid-burst
  logic [63:0] ram [16];
  int          wr_cnt = 0, rd_cnt = 0, rd_delay = 0;
  bit          rd_active = 0;
  logic [3:0]  wr_base = 4'd0, rd_base = 4'd0;
  int          n_wr_bursts = 0, n_rd_bursts = 0;
  logic [3:0]  last_wr_addr = 4'hF, last_rd_addr = 4'hF;

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 64'h0;
    ram[1][31:0]  = 32'hAB4C3E6F;   // byte 8
    ram[1][63:32] = 32'h9D8E2F17;   // byte 12
    ram[2][31:0]  = 32'hD5B8A9C4;   // byte 16
    ram[3][63:32] = 32'h7D4E9F2C;   // byte 28
    ram[4][31:0]  = 32'h2F5E3C7A;   // byte 32
  end

  always @(negedge clk) begin
    br_rd_data_valid = 1'b0;
    if (rst) begin
      rd_active = 0;
      wr_cnt    = 0;
    end else begin
      if (wr_cnt > 0) begin
        ram[4'(wr_base + wr_cnt)] = br_wr_data;
        wr_cnt = (wr_cnt == 3) ? 0 : wr_cnt + 1;
      end
      if (br_cmd_en && br_cmd) begin
        ram[br_addr] = br_wr_data;
        wr_base = br_addr; wr_cnt = 1;
        n_wr_bursts++; last_wr_addr = br_addr;
      end
      if (rd_active) begin
        if (rd_delay > 0) rd_delay--;
        else begin
          br_rd_data_valid = 1'b1;
          br_rd_data = ram[4'(rd_base + rd_cnt)];
          rd_cnt++;
          if (rd_cnt == 2) rd_delay = 1;
          if (rd_cnt == 4) rd_active = 0;
        end
      end
      if (br_cmd_en && !br_cmd) begin
        rd_active = 1; rd_base = br_addr; rd_cnt = 0; rd_delay = 2;
        n_rd_bursts++; last_rd_addr = br_addr;
      end
    end
  end

  // One request; waits (bounded) for a miss to finish and returns the response seen when busy drops
  task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                        output bit miss, output bit first_ready, output bit ready,
                        output logic [31:0] rdata);
    int n;
    @(negedge clk);
    enable = 1'b1; address = a; write_enable = we; data_in = d;
    @(negedge clk);
    enable = 1'b0;
    miss = busy; first_ready = data_out_ready; ready = data_out_ready; rdata = data_out;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL access_timeout addr=%h: busy=%b after %0d cycles, expected 0", a, busy, n);
    end else if (miss) begin
      ready = data_out_ready; rdata = data_out;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (data_out_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", data_out_ready); end
    vectors++; if (br_cmd_en !== 1'b0 || br_cmd !== 1'b0) begin miscompares++; $display("FAIL reset_cmd: got en=%b cmd=%b expected 0/0", br_cmd_en, br_cmd); end
    vectors++; if (data_out !== 32'h0) begin miscompares++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    vectors++; if (br_data_mask !== 8'h00) begin miscompares++; $display("FAIL data_mask: got %h expected 00", br_data_mask); end
  endtask

  task automatic test_read_fill();
    bit miss, fr, rdy; logic [31:0] rd;
    access(32'd16, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b1 || fr !== 1'b0) begin miscompares++; $display("FAIL rd16_miss: got miss=%b ready=%b expected 1/0", miss, fr); end
    vectors++; if (rdy !== 1'b1 || rd !== 32'hD5B8A9C4) begin miscompares++; $display("FAIL rd16_data: got ready=%b data=%h expected 1 d5b8a9c4", rdy, rd); end
    vectors++; if (n_rd_bursts != 1 || last_rd_addr !== 4'd0 || n_wr_bursts != 0) begin miscompares++; $display("FAIL rd16_burst: got rd=%0d addr=%h wr=%0d expected 1 0 0", n_rd_bursts, last_rd_addr, n_wr_bursts); end
    @(negedge clk);
    vectors++; if (data_out_ready !== 1'b0 || data_out !== 32'hD5B8A9C4) begin miscompares++; $display("FAIL ready_pulse: got ready=%b data=%h expected 0 d5b8a9c4", data_out_ready, data_out); end
    access(32'd8, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b0 || rdy !== 1'b1 || rd !== 32'hAB4C3E6F) begin miscompares++; $display("FAIL rd8_hit: got miss=%b ready=%b data=%h expected 0 1 ab4c3e6f", miss, rdy, rd); end
    access(32'd12, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b0 || rdy !== 1'b1 || rd !== 32'h9D8E2F17) begin miscompares++; $display("FAIL rd12_hit: got miss=%b ready=%b data=%h expected 0 1 9d8e2f17", miss, rdy, rd); end
  endtask

  task automatic test_ignore_while_busy();
    bit miss, fr, rdy; logic [31:0] rd; int n;
    @(negedge clk);
    enable = 1'b1; address = 32'd32; write_enable = 4'h0; data_in = 32'h0;
    @(negedge clk);
    vectors++; if (busy !== 1'b1 || data_out_ready !== 1'b0) begin miscompares++; $display("FAIL rd32_first_cycle: got busy=%b ready=%b expected 1/0", busy, data_out_ready); end
    address = 32'd36; write_enable = 4'hF; data_in = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rd32_timeout: busy=%b expected 0", busy); end
    vectors++; if (data_out_ready !== 1'b1 || data_out !== 32'h2F5E3C7A) begin miscompares++; $display("FAIL rd32_data: got ready=%b data=%h expected 1 2f5e3c7a", data_out_ready, data_out); end
    vectors++; if (last_rd_addr !== 4'd4 || n_wr_bursts != 0) begin miscompares++; $display("FAIL rd32_burst: got addr=%h wr=%0d expected 4 0", last_rd_addr, n_wr_bursts); end
    access(32'd36, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("FAIL busy_ignore: got miss=%b data=%h expected 0 00000000", miss, rd); end
  endtask

  task automatic test_byte_merge();
    logic [31:0] wd [3];
    logic [3:0]  be [3];
    logic [31:0] ex [3];
    bit miss, fr, rdy; logic [31:0] rd;
    wd[0] = 32'h000000AD; be[0] = 4'b0001; ex[0] = 32'hAB4C3EAD;
    wd[1] = 32'h00008765; be[1] = 4'b0011; ex[1] = 32'hAB4C8765;
    wd[2] = 32'hFEEF0000; be[2] = 4'b1100; ex[2] = 32'hFEEF8765;
    for (int i = 0; i < 3; i++) begin
      access(32'd8, be[i], wd[i], miss, fr, rdy, rd);
      vectors++; if (miss !== 1'b0 || fr !== 1'b0) begin miscompares++; $display("FAIL wr_hit_%0d: got busy=%b ready=%b expected 0/0", i, miss, fr); end
      access(32'd8, 4'h0, 32'h0, miss, fr, rdy, rd);
      vectors++; if (rdy !== 1'b1 || rd !== ex[i]) begin miscompares++; $display("FAIL merge_%0d: got ready=%b data=%h expected 1 %h", i, rdy, rd, ex[i]); end
    end
  endtask

  task automatic test_writeback();
    bit miss, fr, rdy; logic [31:0] rd; int nw0;
    nw0 = n_wr_bursts;
    access(32'd64, 4'hF, 32'hABCDEF12, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b1 || rdy !== 1'b0) begin miscompares++; $display("FAIL wr64_miss: got miss=%b ready=%b expected 1/0", miss, rdy); end
    vectors++; if (n_wr_bursts != nw0 + 1 || last_wr_addr !== 4'd0 || last_rd_addr !== 4'd8) begin miscompares++; $display("FAIL wr64_bursts: got wr=%0d waddr=%h raddr=%h expected %0d 0 8", n_wr_bursts, last_wr_addr, last_rd_addr, nw0 + 1); end
    vectors++; if (ram[1] !== 64'h9D8E2F17_FEEF8765) begin miscompares++; $display("FAIL wr64_victim: got %h expected 9d8e2f17feef8765", ram[1]); end
    access(32'd64, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b0 || rd !== 32'hABCDEF12) begin miscompares++; $display("FAIL rd64_a: got miss=%b data=%h expected 0 abcdef12", miss, rd); end
    access(32'd64, 4'hF, 32'h1B2D3F42, miss, fr, rdy, rd);
    access(32'd64, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b0 || rd !== 32'h1B2D3F42) begin miscompares++; $display("FAIL rd64_b: got miss=%b data=%h expected 0 1b2d3f42", miss, rd); end
  endtask

  task automatic test_back_to_back();
    bit miss, fr, rdy; logic [31:0] rd;
    access(32'd0, 4'hF, 32'h31323334, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b1) begin miscompares++; $display("FAIL wr0_busy: got %b expected 1", miss); end
    vectors++; if (last_wr_addr !== 4'd8 || ram[8] !== 64'h00000000_1B2D3F42 || last_rd_addr !== 4'd0) begin miscompares++; $display("FAIL wr0_bursts: got waddr=%h ram8=%h raddr=%h expected 8 000000001b2d3f42 0", last_wr_addr, ram[8], last_rd_addr); end
    access(32'd8, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b0 || rd !== 32'hFEEF8765) begin miscompares++; $display("FAIL rd8_after_wb: got miss=%b data=%h expected 0 feef8765", miss, rd); end
    access(32'd28, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b0 || rd !== 32'h7D4E9F2C) begin miscompares++; $display("FAIL rd28: got miss=%b data=%h expected 0 7d4e9f2c", miss, rd); end
    access(32'd0, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (rd !== 32'h31323334) begin miscompares++; $display("FAIL rd0_merged: got %h expected 31323334", rd); end
    // Write then read the same word on consecutive cycles
    @(negedge clk);
    enable = 1'b1; address = 32'd4; write_enable = 4'hF; data_in = 32'h5A5A5A5A;
    @(negedge clk);
    write_enable = 4'h0;
    @(negedge clk);
    enable = 1'b0;
    vectors++; if (busy !== 1'b0 || data_out_ready !== 1'b1 || data_out !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL raw_b2b: got busy=%b ready=%b data=%h expected 0 1 5a5a5a5a", busy, data_out_ready, data_out); end
  endtask

  task automatic test_reset_mid_fill();
    bit miss, fr, rdy; logic [31:0] rd; int nr0, nw0, n;
    nr0 = n_rd_bursts; nw0 = n_wr_bursts;
    @(negedge clk);
    enable = 1'b1; address = 32'd96; write_enable = 4'h0;
    @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (n_rd_bursts == nr0 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    vectors++; if (busy !== 1'b1 || n_rd_bursts != nr0 + 1) begin miscompares++; $display("FAIL rd96_in_fill: got busy=%b bursts=%0d expected 1 %0d", busy, n_rd_bursts, nr0 + 1); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++; if (busy !== 1'b0 || data_out_ready !== 1'b0 || br_cmd_en !== 1'b0) begin miscompares++; $display("FAIL mid_fill_reset: got busy=%b ready=%b cmd_en=%b expected 0 0 0", busy, data_out_ready, br_cmd_en); end
    access(32'd16, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b1 || rd !== 32'hD5B8A9C4) begin miscompares++; $display("FAIL rd16_refetch: got miss=%b data=%h expected 1 d5b8a9c4", miss, rd); end
    vectors++; if (n_wr_bursts != nw0 || last_rd_addr !== 4'd0) begin miscompares++; $display("FAIL rd16_no_wb: got wr=%0d raddr=%h expected %0d 0", n_wr_bursts, last_rd_addr, nw0); end
    access(32'd32, 4'h0, 32'h0, miss, fr, rdy, rd);
    vectors++; if (miss !== 1'b1 || rd !== 32'h2F5E3C7A) begin miscompares++; $display("FAIL rd32_refetch: got miss=%b data=%h expected 1 2f5e3c7a", miss, rd); end
`ifdef CACHE_STATS_EN
    vectors++; if (stat_misses !== 32'd2 || stat_hits !== 32'd0) begin miscompares++; $display("FAIL stats: got hits=%0d misses=%0d expected 0 2", stat_hits, stat_misses); end
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_fill();
    test_ignore_while_busy();
    test_byte_merge();
    test_writeback();
    test_back_to_back();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/burst_cache.md
Name: burst_cache

Overview:
- Direct-mapped, write-back data cache between a 32-bit CPU-side load/store port and a 64-bit burst RAM (PSRAM-style controller).
- Each line holds 4 × 64-bit RAM words (32 bytes, 8 × 32-bit words).
- Hits complete in one cycle. Misses evict a dirty victim with a 4-beat write burst, then refill with a 4-beat read burst.

Parameters:
- LineIndexBitWidth, 1, log2 of number of cache lines.
- RamAddressBitWidth, 4, width of br_addr (RAM word address).
- RamAddressingMode, 3, log2 bytes per RAM address unit (3 = 64-bit words).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  request valid this cycle
- write_enable  in  4  byte enables; 0 = read, nonzero = write
- address  in  32  byte address; bits [1:0] ignored
- data_in  in  32  write data, byte lanes per write_enable
- data_out  out  32  read data
- data_out_ready  out  1  data_out valid (one-cycle pulse per read)
- busy  out  1  request in progress; new requests ignored
- br_cmd  out  1  0 = read, 1 = write
- br_cmd_en  out  1  one-cycle command strobe
- br_addr  out  RamAddressBitWidth  RAM word address of line start
- br_wr_data  out  64  write burst beat
- br_data_mask  out  8  constant 0 (all bytes written)
- br_rd_data  in  64  read burst beat
- br_rd_data_valid  in  1  read beat valid

Behaviour:
- Address split with L = LineIndexBitWidth:
  - word-in-line = address[4:2].
  - index = address[5 +: L].
  - tag = address[RamAddressBitWidth+RamAddressingMode-1 : 5+L].
  - Higher address bits are ignored.
- br_addr = {tag, index, 2'b00}.
- Line storage: 4 × 64 bits. 32-bit word w lives in 64-bit beat w/2; even w = low half, odd w = high half.
- Per-line metadata: valid, dirty, tag.
- Reset:
  - All valid and dirty bits cleared.
  - busy=0, data_out_ready=0, br_cmd_en=0, br_cmd=0, data_out=0.
  - FSM to IDLE; an in-flight burst is abandoned.
- Requests are sampled only in IDLE when enable=1.
- Read hit: data_out and data_out_ready=1 are registered on the next edge; busy stays 0.
- Write hit: selected bytes are merged on the next edge and dirty set; busy stays 0; data_out_ready=0.
- A read issued the cycle after a write to the same word returns the new data.
- Miss: the request (address, write_enable, data_in) is latched and busy=1 from the next edge until completion.
- FSM states:
  - IDLE
  - WB: when the victim is valid and dirty. Pulse br_cmd_en with br_cmd=1 and br_addr = victim line; drive beats 0..3 on br_wr_data on 4 consecutive cycles starting with the cmd_en cycle.
  - FILL_CMD: the cycle after the last write beat, or directly on a clean/invalid miss. Pulse br_cmd_en with br_cmd=0 and the new line address.
  - FILL_WAIT: capture beat k into slot k on the k-th br_rd_data_valid cycle (k=0..3).
  - DONE: after beat 3. Set tag and valid; clear dirty. A latched write is merged and sets dirty. A latched read drives data_out/data_out_ready=1. busy=0. Return to IDLE.
- data_out_ready is a one-cycle pulse; data_out holds its value until the next read completes.
- br_cmd_en is never asserted outside WB/FILL_CMD.
- enable asserted while busy=1 is ignored.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs stat_hits (32 bits) and stat_misses (32 bits). Each increments once per accepted request (hit or miss respectively), wraps modulo 2^32, and clears on rst.
- Undefined: those ports and counters do not exist.

Test Plan:
RAM is preloaded with bytes 8→0xAB4C3E6F, 12→0x9D8E2F17, 16→0xD5B8A9C4, 28→0x7D4E9F2C, 32→0x2F5E3C7A.
- Read 16 after reset → busy for the fill, read burst at br_addr 0, then data_out_ready with 0xD5B8A9C4. Then read 8 → next-cycle hit 0xAB4C3E6F; read 12 → 0x9D8E2F17.
- Read 32 → data_out_ready=0 the cycle after the request (miss on line 1), later 0x2F5E3C7A.
- On line 0, apply in order:
  - write 0x000000AD with enable 0001 → read 8 returns 0xAB4C3EAD.
  - write 0x00008765 with enable 0011 → read 8 returns 0xAB4C8765.
  - write 0xFEEF0000 with enable 1100 → read 8 returns 0xFEEF8765.
- Write 0xABCDEF12 to 64 → write burst at br_addr 0 with the dirty line, then fill at br_addr 8; read 64 returns 0xABCDEF12. Write 0x1B2D3F42 to 64 hit; read 64 returns 0x1B2D3F42.
- Write 0x31323334 to 0 → busy=1 the next cycle (write-back of line 64, refill of line 0). Then read 8 → hit 0xFEEF8765, proving the earlier write-back. Read 28 → 0x7D4E9F2C.
- Assert rst during FILL_WAIT → busy=0 and all lines invalid; the next read of 16 misses and refetches.
